// File: rtl/alu_pkg.sv
// Shared definitions for the streaming ALU: opcodes, FSM state encoding and flag bit positions.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_ROL  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  // Positions inside the registered flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_E = 4;
  localparam int FLAG_W = 5;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic               running;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_next;

  // done is combinational so the final partial product is visible on the completing edge
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = running && (count == CW'(WIDTH - 1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
    end else if (running) begin
      acc     <= acc_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      count   <= count + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_stream.sv
// Registered streaming ALU with valid/ready handshake and NZCV-style flags.
// Define ALU_STREAM_MUL_EN to build the iterative multiplier for opcode 1100.
module alu_stream
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             err,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  logic [0:0]         state;
  logic               accept;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] rol_wide;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_err;
  logic               op_load;
  logic               mul_load;
  logic [WIDTH-1:0]   load_res;
  logic [FLAG_W-1:0]  load_flags;
  logic [FLAG_W-1:0]  flags;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sh       = b[SHW-1:0];
  assign rol_wide = {a, a} << sh;

  // Single-cycle operations; MUL lands in the default arm and is overridden when the multiplier exists
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        {alu_c, alu_res} = {1'b0, a} - {1'b0, b};
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SHL:  alu_res = a << sh;
      OP_SHR:  alu_res = a >> sh;
      OP_SRA:  alu_res = $signed(a) >>> sh;
      OP_ROL:  alu_res = rol_wide[2*WIDTH-1:WIDTH];
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_STREAM_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = accept && (op == OP_MUL);
  assign op_load   = accept && (op != OP_MUL);
  assign mul_load  = mul_done;
  assign busy      = (state == ST_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (mul_start) begin
      state <= ST_MUL;
    end else if (mul_done) begin
      state <= ST_IDLE;
    end
  end

  always_comb begin
    load_res = alu_res;
    load_flags = '0;
    load_flags[FLAG_C] = alu_c;
    load_flags[FLAG_V] = alu_v;
    load_flags[FLAG_E] = alu_err;
    if (mul_done) begin
      load_res = mul_prod[WIDTH-1:0];
      load_flags[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
      load_flags[FLAG_V] = 1'b0;
      load_flags[FLAG_E] = 1'b0;
    end
    load_flags[FLAG_Z] = (load_res == '0);
    load_flags[FLAG_N] = load_res[WIDTH-1];
  end
`else
  assign state    = ST_IDLE;
  assign op_load  = accept;
  assign mul_load = 1'b0;
  assign busy     = 1'b0;

  always_comb begin
    load_res = alu_res;
    load_flags = '0;
    load_flags[FLAG_C] = alu_c;
    load_flags[FLAG_V] = alu_v;
    load_flags[FLAG_E] = alu_err;
    load_flags[FLAG_Z] = (alu_res == '0);
    load_flags[FLAG_N] = alu_res[WIDTH-1];
  end
`endif

  // Zero/negative are captured with the result so reset can clear every flag together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else if (op_load || mul_load) begin
      result    <= load_res;
      flags     <= load_flags;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign zero     = flags[FLAG_Z];
  assign carry    = flags[FLAG_C];
  assign overflow = flags[FLAG_V];
  assign negative = flags[FLAG_N];
  assign err      = flags[FLAG_E];

endmodule

// File: doc/alu_stream.md
Name: alu_stream

Overview:
- Parametrised, registered successor of the team's 8-bit combinational ALU.
- Generalised operand width, 4-bit opcode with signed, rotate, compare and shift-by-amount ops, and full NZCV-style flags.
- Valid/ready handshake on input and output, plus an iterative multi-cycle multiplier.
- Sits between the board's operand/switch front end and the display/result consumer; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be ≥4 and a power of two.
- SHW, $clog2(WIDTH), derived localparam: shift-amount width taken from b[SHW-1:0].

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block accepts operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B, or shift amount in b[SHW-1:0]
- op  in  4  operation code
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- carry  out  1  carry/borrow/high-product flag
- overflow  out  1  signed overflow (ADD/SUB only)
- negative  out  1  result[WIDTH-1]
- err  out  1  illegal or compiled-out opcode
- busy  out  1  multiplier iterating

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, out_valid=0, result=0, all flags=0, busy=0, counter=0.
  - Reset mid-MUL aborts the operation; no output is produced.
- Opcodes:
  - 0000 ADD: {carry,result}=a+b.
  - 0001 SUB: {carry,result}=a-b; carry=1 means borrow (a<b unsigned).
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOR.
  - 0110 SHL: a<<b[SHW-1:0].
  - 0111 SHR: logical a>>b[SHW-1:0].
  - 1000 SRA: arithmetic >>.
  - 1001 ROL: rotate left by b[SHW-1:0].
  - 1010 SLT: signed a<b, result=1/0.
  - 1011 SLTU: unsigned a<b, result=1/0.
  - 1100 MUL (optional feature): low WIDTH bits of unsigned a*b; carry=1 if upper WIDTH bits ≠0.
  - 1101–1111: illegal; result=0, err=1.
- Flags:
  - carry=0 for every op except ADD/SUB/MUL.
  - overflow computed only for ADD/SUB (operand signs equal, or differ for SUB, and result sign differs); 0 otherwise.
  - zero and negative are always derived from the registered result; illegal op therefore gives zero=1.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on a rising edge with in_valid && in_ready.
  - Output is held stable while out_valid && !out_ready.
  - out_valid drops after the handshake unless a new result is loaded on the same edge.
- Latency:
  - Single-cycle ops: out_valid at the edge after acceptance. Back-to-back throughput is 1 op/cycle with out_ready=1.
  - MUL: accept → state MUL, busy=1, in_ready=0. Shift-add, one bit per cycle, WIDTH iterations. out_valid asserts exactly WIDTH edges after acceptance, then state returns to IDLE.
  - The output slot is always empty when MUL completes, because acceptance required it to be freed.
- FSM transitions:
  - IDLE --accept MUL--> MUL
  - MUL --count==WIDTH-1--> IDLE, loading the result
  - IDLE --accept other--> IDLE, loading the result
- Operand/op changes while not accepted, or during MUL, are ignored; operands are latched at acceptance.
- Shift amount 0 returns a unchanged. Only b[SHW-1:0] is used; upper bits of b are ignored.

Optional Feature:
- Macro ALU_STREAM_MUL_EN.
- Defined: opcode 1100 runs the iterative multiplier; busy and the MUL state exist.
- Undefined: 1100 is treated as illegal (single cycle, result=0, zero=1, err=1); busy is tied 0; no multiplier registers are synthesised.

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_ADD…OP_MUL), state encoding (ST_IDLE, ST_MUL), flag bit indices.
- One sub-module: alu_mul_iter (shift-add multiplier with start/done, parametrised WIDTH), instantiated only under ALU_STREAM_MUL_EN.
- Combinational op decode stays in alu_stream.

Test Plan:
- WIDTH=8, ADD a=0xFF b=0x01, out_ready=1 → next cycle result=0x00, zero=1, carry=1, overflow=0, negative=0.
- SUB a=0x80 b=0x01 → result=0x7F, overflow=1, carry=0; SUB a=0x03 b=0x05 → result=0xFE, carry=1, negative=1.
- SRA a=0x90 b=0x03 → 0xF2; ROL a=0x81 b=0x01 → 0x03; SLT a=0xFF b=0x01 → 0x01; SLTU same operands → 0x00.
- Hold out_ready=0 after an ADD; assert in_valid with a new op → in_ready=0, result unchanged for 5 cycles; raise out_ready → handshake, new op accepted the same edge.
- MUL (feature on) a=0x10 b=0x20 → busy for 8 cycles, out_valid 8 edges after acceptance, result=0x00, carry=1, zero=1; a=0x0C b=0x0B → 0x84, carry=0. Assert rst_n low at cycle 4 of a MUL → out_valid never rises, all outputs 0.
- op=1110 → result=0, err=1, zero=1; with the feature off, op=1100 → identical err response in 1 cycle.
